pc_unit: RTL and testbench

- Parametrised fetch program-counter unit; next generation of the single-register PC.
- Adds configurable width, reset and step values, stall hold, trap redirect with priority, and an internal circular return-address stack (RAS) for call/return prediction.
- Sits at the head of the fetch stage: drives the instruction-memory address and receives redirects from execute/trap logic.

---
 rtl/pc_unit_pkg.sv | 33 +++
 rtl/pc_unit_ras.sv | 47 ++++
 rtl/pc_unit.sv | 82 ++++++++
 tb/tb_pc_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared fetch-stage types and constants for the program-counter unit.
package pc_unit_pkg;

  localparam int unsigned ADDR_W_DEFAULT       = 32;
  localparam int unsigned INSTR_STEP           = 4;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef logic                      clock_t;
  typedef logic                      bool_t;
  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;
  typedef addr_t                     addr_reg_t;

  typedef enum logic [2:0] {
    SelReset,
    SelTrap,
    SelJump,
    SelRet,
    SelStall,
    SelSeq
  } pc_sel_e;

  // Next-PC source in priority order; ret_taken already excludes an empty stack.
  function automatic pc_sel_e pc_select(bool_t rst_n, bool_t trap, bool_t jump,
                                        bool_t ret_taken, bool_t stall);
    if (!rst_n)         return SelReset;
    else if (trap)      return SelTrap;
    else if (jump)      return SelJump;
    else if (ret_taken) return SelRet;
    else if (stall)     return SelStall;
    else                return SelSeq;
  endfunction

endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack with saturating occupancy; oldest entry is overwritten when full.
module pc_unit_ras #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] top_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  ptr_q;
  logic [PtrW-1:0]  ptr_inc;
  logic [CntW-1:0]  cnt_q;

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign ptr_inc  = ptr_q + 1'b1;
  assign top_data = mem_q[ptr_q];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(Depth));

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_inc;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst_n && push) mem_q[ptr_inc] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: reset/trap/jump/return/stall/sequential next-PC selection
// with a return-address stack for call/return prediction. State updates on falling edge.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W       = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT),
  parameter int unsigned          STEP         = INSTR_STEP,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              trap_enable,
  input  logic [ADDR_W-1:0] trap_address,
  input  logic              jump_enable,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              call_enable,
  input  logic              ret_enable,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_next,
  output logic              misaligned_out,
  output logic              ras_empty,
  output logic              ras_full
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push, ras_pop;
  pc_sel_e           sel;

  assign link_addr = pc_q + ADDR_W'(STEP);
  assign ras_push  = jump_enable & call_enable & ~trap_enable;
  assign ras_pop   = ret_enable & ~jump_enable & ~trap_enable & ~ras_empty;

  always_comb begin
    sel   = pc_select(rst_n, trap_enable, jump_enable, ras_pop, stall);
    pc_d  = pc_q;
    mis_d = 1'b0;
    case (sel)
      SelReset: pc_d = RESET_VECTOR;
      SelTrap: begin
        pc_d  = {trap_address[ADDR_W-1:2], 2'b00};
        mis_d = |trap_address[1:0];
      end
      SelJump: begin
        pc_d  = {jump_address[ADDR_W-1:2], 2'b00};
        mis_d = |jump_address[1:0];
      end
      SelRet:   pc_d = ras_top;
      SelStall: pc_d = pc_q;
      SelSeq:   pc_d = link_addr;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(negedge clk) begin
    pc_q  <= pc_d;
    mis_q <= mis_d;
  end

  pc_unit_ras #(
    .Depth(RAS_DEPTH),
    .Width(ADDR_W)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(link_addr),
    .top_data (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign pc_out         = pc_q;
  assign pc_next        = pc_d;
  assign misaligned_out = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized run against a queue model.
module tb_pc_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, stall, trap_enable, jump_enable, call_enable, ret_enable;
  logic [31:0] trap_address, jump_address;
  logic [31:0] pc_out, pc_next;
  logic        misaligned_out, ras_empty, ras_full;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  pc_unit #(
    .ADDR_W      (32),
    .RESET_VECTOR(32'h0),
    .STEP        (4),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .trap_enable   (trap_enable),
    .trap_address  (trap_address),
    .jump_enable   (jump_enable),
    .jump_address  (jump_address),
    .call_enable   (call_enable),
    .ret_enable    (ret_enable),
    .pc_out        (pc_out),
    .pc_next       (pc_next),
    .misaligned_out(misaligned_out),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_next();
    if (!rst_n) return 32'h0;
    if (trap_enable) return trap_address & 32'hFFFF_FFFC;
    if (jump_enable) return jump_address & 32'hFFFF_FFFC;
    if (ret_enable && m_ras.size() > 0) return m_ras[$];
    if (stall) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic model_edge();
    logic [31:0] nxt;
    nxt = model_next();
    m_mis = 1'b0;
    if (!rst_n) begin
      m_ras.delete();
    end else if (trap_enable) begin
      m_mis = (trap_address % 4) != 0;
    end else if (jump_enable) begin
      m_mis = (jump_address % 4) != 0;
      if (call_enable) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end else if (ret_enable && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
    m_pc = nxt;
  endtask

  task automatic set_in(input logic rn, input logic st, input logic tr, input logic [31:0] ta,
                        input logic je, input logic [31:0] ja, input logic ce, input logic re);
    rst_n = rn; stall = st; trap_enable = tr; trap_address = ta;
    jump_enable = je; jump_address = ja; call_enable = ce; ret_enable = re;
    #1;
  endtask

  task automatic cycle();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
    checks++;
    if (pc_next !== 32'h0) begin
      failures++; $display("FAIL reset_pc_next got=%h want=%h", pc_next, 32'h0);
    end
    cycle();
    cycle();
    checks++;
    if (pc_out !== 32'h0) begin
      failures++; $display("FAIL reset_pc got=%h want=%h", pc_out, 32'h0);
    end
    checks++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0 || misaligned_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b want=100", ras_empty, ras_full, misaligned_out);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checks++;
      if (pc_out !== 32'(4 * i)) begin
        failures++; $display("FAIL reset_release_step%0d got=%h want=%h", i, pc_out, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_redirect();
    cycle();
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (pc_out !== 32'h10) begin
        failures++; $display("FAIL stall_hold%0d got=%h want=%h", i, pc_out, 32'h10);
      end
    end
    set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
    cycle();
    checks++;
    if (pc_out !== 32'h80) begin
      failures++; $display("FAIL stall_jump got=%h want=%h", pc_out, 32'h80);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (pc_out !== 32'h84) begin
      failures++; $display("FAIL stall_release got=%h want=%h", pc_out, 32'h84);
    end
  endtask

  task automatic test_priority();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h90, 1'b1, 1'b0);
    cycle();
    // Trap beats jump, call and return; the stack must be left as is.
    set_in(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1);
    cycle();
    checks++;
    if (pc_out !== 32'h100 || misaligned_out !== 1'b0 || ras_empty !== 1'b0) begin
      failures++;
      $display("FAIL priority_trap got=%h/%b/%b want=%h/0/0", pc_out, misaligned_out, ras_empty,
               32'h100);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle();
    checks++;
    if (pc_out !== 32'h88 || ras_empty !== 1'b1) begin
      failures++; $display("FAIL priority_ras_kept got=%h/%b want=%h/1", pc_out, ras_empty, 32'h88);
    end
  endtask

  task automatic test_call_return();
    logic [31:0] want[5];
    want = '{32'h20, 32'h400, 32'h404, 32'h24, 32'h28};
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle();
    checks++;
    if (pc_out !== want[3] || ras_empty !== 1'b1) begin
      failures++; $display("FAIL call_ret got=%h/%b want=%h/1", pc_out, ras_empty, want[3]);
    end
    cycle();
    checks++;
    if (pc_out !== want[4]) begin
      failures++; $display("FAIL ret_empty got=%h want=%h", pc_out, want[4]);
    end
  endtask

  task automatic test_ras_overflow();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    cycle();
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'(k * 'h100), 1'b1, 1'b0);
      cycle();
    end
    checks++;
    if (ras_full !== 1'b1 || pc_out !== 32'h500) begin
      failures++; $display("FAIL ovf_full got=%b/%h want=1/%h", ras_full, pc_out, 32'h500);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 4; k >= 1; k--) begin
      cycle();
      checks++;
      if (pc_out !== 32'(k * 'h100 + 4)) begin
        failures++; $display("FAIL ovf_ret%0d got=%h want=%h", k, pc_out, 32'(k * 'h100 + 4));
      end
    end
    checks++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      failures++; $display("FAIL ovf_drained got=%b%b want=10", ras_empty, ras_full);
    end
  endtask

  task automatic test_wrap_misalign();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (pc_out !== 32'h0) begin
      failures++; $display("FAIL wrap got=%h want=%h", pc_out, 32'h0);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h82, 1'b0, 1'b0);
    cycle();
    checks++;
    if (pc_out !== 32'h80 || misaligned_out !== 1'b1) begin
      failures++; $display("FAIL misalign got=%h/%b want=%h/1", pc_out, misaligned_out, 32'h80);
    end
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle();
    checks++;
    if (pc_out !== 32'h84 || misaligned_out !== 1'b0) begin
      failures++; $display("FAIL misalign_clear got=%h/%b want=%h/0", pc_out, misaligned_out, 32'h84);
    end
  endtask

  task automatic test_random();
    logic [31:0] ta, ja, exp_next;
    for (int i = 0; i < 400; i++) begin
      ta = $urandom();
      ja = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
      set_in($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, ta,
             $urandom_range(0, 3) == 0, ja, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      exp_next = model_next();
      checks++;
      if (pc_next !== exp_next) begin
        failures++; $display("FAIL rnd_pc_next[%0d] got=%h want=%h", i, pc_next, exp_next);
      end
      cycle();
      checks++;
      if (pc_out !== m_pc || misaligned_out !== m_mis) begin
        failures++;
        $display("FAIL rnd_pc[%0d] got=%h/%b want=%h/%b", i, pc_out, misaligned_out, m_pc, m_mis);
      end
      checks++;
      if (ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == DEPTH)) begin
        failures++;
        $display("FAIL rnd_ras[%0d] got=%b%b size=%0d", i, ras_empty, ras_full, m_ras.size());
      end
    end
  endtask

  initial begin
    m_pc  = 32'h0;
    m_mis = 1'b0;
    test_reset();
    test_stall_redirect();
    test_priority();
    test_call_return();
    test_ras_overflow();
    test_wrap_misalign();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
